// File: rtl/dvp_tx_controller.sv
// DVP transmitter: turns a byte stream into a raster-timed DVP frame
// with PCLK, VSYNC, HSYNC, HREF and data changing on PCLK falling edges.
module dvp_tx_controller #(
  parameter int DVP_DATA_W = 8,
  parameter int PCLK_HALF  = 3,
  parameter int H_ACTIVE   = 640,
  parameter int LINE_LEN   = 1568,
  parameter int HS_LEN     = 160,
  parameter int HBP_LEN    = 80,
  parameter int VS_LINES   = 3,
  parameter int VBP_LINES  = 17,
  parameter int V_ACTIVE   = 480,
  parameter int VFP_LINES  = 10,
  parameter int WAKE_PCLK  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [DVP_DATA_W-1:0] pxl_data_i,
  input  logic                  pxl_valid_i,
  output logic                  pxl_ready_o,
  output logic                  dvp_pclk_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_hsync_o,
  output logic                  dvp_href_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  dvp_pwdn_o,
  output logic                  underflow_o,
  output logic                  frame_done_o
);

  localparam int HMAX = (LINE_LEN > WAKE_PCLK) ? LINE_LEN : WAKE_PCLK;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int VM1  = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
  localparam int VM2  = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
  localparam int VW   = $clog2(VMAX + 1);
  localparam int DW   = $clog2(PCLK_HALF + 1);

  localparam logic [HW-1:0] HREF_LO = HW'(HS_LEN + HBP_LEN);
  localparam logic [HW-1:0] HREF_HI = HW'(HS_LEN + HBP_LEN + H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE, S_WAKE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div;
  logic [HW-1:0]   h_cnt, h_n;
  logic [VW-1:0]   v_cnt, v_n, lines_m1;
  logic            tc, fall, line_end;
  logic            frame_end, href_n, hsync_n;

  assign tc       = div == DW'(PCLK_HALF - 1);
  assign fall     = (state != S_IDLE) && dvp_pclk_o && tc;
  assign line_end = h_cnt == HW'(LINE_LEN - 1);

  always_comb begin
    case (state)
      S_VSYNC:  lines_m1 = VW'(VS_LINES - 1);
      S_VBP:    lines_m1 = VW'(VBP_LINES - 1);
      S_ACTIVE: lines_m1 = VW'(V_ACTIVE - 1);
      default:  lines_m1 = VW'(VFP_LINES - 1);
    endcase
  end

  always_comb begin
    state_n   = state;
    h_n       = h_cnt;
    v_n       = v_cnt;
    frame_end = 1'b0;
    if (state == S_IDLE) begin
      if (en_i) begin
        state_n = S_WAKE;
        h_n     = '0;
        v_n     = '0;
      end
    end else if (fall) begin
      if (state == S_WAKE) begin
        if (h_cnt == HW'(WAKE_PCLK - 1)) begin
          state_n = S_VSYNC;
          h_n     = '0;
        end else begin
          h_n = h_cnt + HW'(1);
        end
      end else if (line_end) begin
        h_n = '0;
        if (v_cnt == lines_m1) begin
          v_n = '0;
          unique case (1'b1)
            state == S_VSYNC:  state_n = S_VBP;
            state == S_VBP:    state_n = S_ACTIVE;
            state == S_ACTIVE: state_n = S_VFP;
            default: begin
              frame_end = 1'b1;
              state_n   = en_i ? S_VSYNC : S_IDLE;
            end
          endcase
        end else begin
          v_n = v_cnt + VW'(1);
        end
      end else begin
        h_n = h_cnt + HW'(1);
      end
    end
    hsync_n = (state_n == S_ACTIVE) && (h_n >= HW'(HS_LEN));
    href_n  = (state_n == S_ACTIVE) && (h_n >= HREF_LO) && (h_n < HREF_HI);
  end

  // the byte is popped on the same edge that puts it on the bus
  assign pxl_ready_o = fall && href_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      div          <= '0;
      dvp_pclk_o   <= 1'b0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      dvp_vsync_o  <= 1'b0;
      dvp_hsync_o  <= 1'b0;
      dvp_href_o   <= 1'b0;
      dvp_d_o      <= '0;
      dvp_pwdn_o   <= 1'b1;
      underflow_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      h_cnt        <= h_n;
      v_cnt        <= v_n;
      dvp_pwdn_o   <= state_n == S_IDLE;
      frame_done_o <= frame_end;
      if (state == S_IDLE) begin
        div        <= '0;
        dvp_pclk_o <= 1'b0;
      end else if (tc) begin
        div        <= '0;
        dvp_pclk_o <= ~dvp_pclk_o;
      end else begin
        div <= div + DW'(1);
      end
      if (fall) begin
        dvp_vsync_o <= state_n == S_VSYNC;
        dvp_hsync_o <= hsync_n;
        dvp_href_o  <= href_n;
        dvp_d_o     <= (href_n && pxl_valid_i) ? pxl_data_i : '0;
        if (frame_end)
          underflow_o <= 1'b0;
        else if (href_n && !pxl_valid_i)
          underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_tx_controller.sv
// Bench for dvp_tx_controller with a tiny raster; bytes are tracked
// through a scoreboard and raster timing is checked against a table.
module tb_dvp_tx_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b0;
  logic [7:0] pxl_data_i = '0;
  logic       pxl_valid_i = 1'b0;
  logic       pxl_ready_o, dvp_pclk_o, dvp_vsync_o, dvp_hsync_o;
  logic       dvp_href_o, dvp_pwdn_o, underflow_o, frame_done_o;
  logic [7:0] dvp_d_o;

  dvp_tx_controller #(
    .DVP_DATA_W(8), .PCLK_HALF(2), .H_ACTIVE(4), .LINE_LEN(12),
    .HS_LEN(2), .HBP_LEN(2), .VS_LINES(1), .VBP_LINES(1),
    .V_ACTIVE(2), .VFP_LINES(1), .WAKE_PCLK(2)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i),
    .pxl_data_i(pxl_data_i), .pxl_valid_i(pxl_valid_i),
    .pxl_ready_o(pxl_ready_o), .dvp_pclk_o(dvp_pclk_o),
    .dvp_vsync_o(dvp_vsync_o), .dvp_hsync_o(dvp_hsync_o),
    .dvp_href_o(dvp_href_o), .dvp_d_o(dvp_d_o),
    .dvp_pwdn_o(dvp_pwdn_o), .underflow_o(underflow_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic       vs;
    logic       hs;
    logic       hr;
    logic [7:0] d;
  } vec_t;

  logic [7:0] sb[$];
  int         vs_rise[$];
  int         rise_cnt = 0;
  int         ready_cnt = 0;
  int         fd_cnt = 0;
  int         byte_idx = 0;
  int         drop_idx = -1;
  logic       pclk_q = 1'b0;
  logic       vs_q = 1'b0;
  logic       pwdn_seen = 1'b0;
  logic       uf_at_fd = 1'b0;
  logic       cap_vs[256], cap_hs[256], cap_hr[256], cap_uf[256], cap_pd[256];
  logic [7:0] cap_d[256];

  // source: record what the DUT should show, then move to the next byte
  initial begin
    forever begin
      @(negedge clk);
      if (pxl_ready_o) begin
        sb.push_back(pxl_valid_i ? pxl_data_i : 8'h00);
        ready_cnt++;
        @(posedge clk);
        #1;
        byte_idx++;
        pxl_data_i  = 8'(byte_idx);
        pxl_valid_i = byte_idx != drop_idx;
      end
    end
  end

  always @(negedge clk) begin
    if (dvp_pclk_o && !pclk_q) begin
      rise_cnt++;
      if (rise_cnt < 256) begin
        cap_vs[rise_cnt] = dvp_vsync_o;
        cap_hs[rise_cnt] = dvp_hsync_o;
        cap_hr[rise_cnt] = dvp_href_o;
        cap_uf[rise_cnt] = underflow_o;
        cap_pd[rise_cnt] = dvp_pwdn_o;
        cap_d[rise_cnt]  = dvp_d_o;
      end
      if (dvp_pwdn_o) pwdn_seen = 1'b1;
      if (dvp_href_o) begin
        if (sb.size() == 0) chk("sb_underrun", 1, 0);
        else chk("pixel", int'(dvp_d_o), int'(sb.pop_front()));
      end
      if (dvp_vsync_o && !vs_q) vs_rise.push_back(rise_cnt);
      vs_q = dvp_vsync_o;
    end
    pclk_q = dvp_pclk_o;
    if (frame_done_o) begin
      fd_cnt++;
      uf_at_fd = underflow_o;
    end
  end

  task automatic start(input int drop);
    rise_cnt    = 0;
    ready_cnt   = 0;
    fd_cnt      = 0;
    byte_idx    = 0;
    drop_idx    = drop;
    pwdn_seen   = 1'b0;
    vs_q        = 1'b0;
    pxl_data_i  = 8'h00;
    pxl_valid_i = drop != 0;
    sb.delete();
    vs_rise.delete();
  endtask

  task automatic wait_fd(input int n, input string name);
    int i = 0;
    while (fd_cnt < n && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(fd_cnt >= n), 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_rise(input int n, input string name);
    int i = 0;
    while (rise_cnt < n && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(rise_cnt >= n), 1);
  endtask

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1,  0, 0, 0, 8'h00};
    tbl[1]  = '{2,  0, 0, 0, 8'h00};
    tbl[2]  = '{3,  1, 0, 0, 8'h00};
    tbl[3]  = '{14, 1, 0, 0, 8'h00};
    tbl[4]  = '{15, 0, 0, 0, 8'h00};
    tbl[5]  = '{26, 0, 0, 0, 8'h00};
    tbl[6]  = '{27, 0, 0, 0, 8'h00};
    tbl[7]  = '{28, 0, 0, 0, 8'h00};
    tbl[8]  = '{29, 0, 1, 0, 8'h00};
    tbl[9]  = '{31, 0, 1, 1, 8'h00};
    tbl[10] = '{32, 0, 1, 1, 8'h01};
    tbl[11] = '{34, 0, 1, 1, 8'h03};
    tbl[12] = '{35, 0, 1, 0, 8'h00};
    tbl[13] = '{38, 0, 1, 0, 8'h00};
    tbl[14] = '{39, 0, 0, 0, 8'h00};
    tbl[15] = '{43, 0, 1, 1, 8'h04};
    tbl[16] = '{46, 0, 1, 1, 8'h07};
    tbl[17] = '{47, 0, 1, 0, 8'h00};
    tbl[18] = '{51, 0, 0, 0, 8'h00};
    tbl[19] = '{62, 0, 0, 0, 8'h00};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_pclk", int'(dvp_pclk_o), 0);
    chk("rst_pwdn", int'(dvp_pwdn_o), 1);
    chk("rst_vs", int'(dvp_vsync_o), 0);
    chk("rst_ready", int'(pxl_ready_o), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single frame from a one-cycle enable pulse
    start(-1);
    en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    chk("pwdn_low", int'(dvp_pwdn_o), 0);
    wait_fd(1, "single_fd_timeout");
    for (int i = 0; i < 20; i++) begin
      int k;
      k = tbl[i].idx;
      chk($sformatf("vs@%0d", k), int'(cap_vs[k]), int'(tbl[i].vs));
      chk($sformatf("hs@%0d", k), int'(cap_hs[k]), int'(tbl[i].hs));
      chk($sformatf("href@%0d", k), int'(cap_hr[k]), int'(tbl[i].hr));
      chk($sformatf("d@%0d", k), int'(cap_d[k]), int'(tbl[i].d));
      chk($sformatf("pwdn@%0d", k), int'(cap_pd[k]), 0);
    end
    chk("single_rises", rise_cnt, 62);
    chk("single_ready", ready_cnt, 8);
    chk("single_fd", fd_cnt, 1);
    chk("single_sb", sb.size(), 0);
    chk("single_idle_pwdn", int'(dvp_pwdn_o), 1);
    chk("single_idle_pclk", int'(dvp_pclk_o), 0);

    // underflow on the third byte
    start(2);
    en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    wait_fd(1, "uf_fd_timeout");
    chk("uf_ready", ready_cnt, 8);
    chk("uf_d3", int'(cap_d[33]), 0);
    chk("uf_before", int'(cap_uf[32]), 0);
    chk("uf_set", int'(cap_uf[33]), 1);
    chk("uf_held", int'(cap_uf[62]), 1);
    chk("uf_clear_at_fd", int'(uf_at_fd), 0);
    chk("uf_after", int'(underflow_o), 0);
    chk("uf_sb", sb.size(), 0);

    // continuous frames, en dropped during the second frame
    start(-1);
    en_i = 1'b1;
    wait_rise(70, "cont_rise_timeout");
    en_i = 1'b0;
    wait_fd(2, "cont_fd_timeout");
    chk("cont_vs_count", vs_rise.size(), 2);
    if (vs_rise.size() == 2) begin
      chk("cont_first_vs", vs_rise[0], 3);
      chk("cont_period", vs_rise[1] - vs_rise[0], 60);
    end
    chk("cont_no_wake", int'(pwdn_seen), 0);
    chk("cont_ready", ready_cnt, 16);
    chk("cont_fd", fd_cnt, 2);
    chk("cont_rises", rise_cnt, 122);
    chk("cont_idle_pwdn", int'(dvp_pwdn_o), 1);

    // late disable mid-ACTIVE still finishes the frame
    start(-1);
    en_i = 1'b1;
    wait_rise(32, "late_rise_timeout");
    en_i = 1'b0;
    wait_fd(1, "late_fd_timeout");
    chk("late_ready", ready_cnt, 8);
    chk("late_fd", fd_cnt, 1);
    chk("late_rises", rise_cnt, 62);
    chk("late_pwdn", int'(dvp_pwdn_o), 1);

    // asynchronous reset mid-ACTIVE
    start(-1);
    en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    wait_rise(32, "rst_rise_timeout");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_pclk", int'(dvp_pclk_o), 0);
    chk("mid_rst_href", int'(dvp_href_o), 0);
    chk("mid_rst_hs", int'(dvp_hsync_o), 0);
    chk("mid_rst_d", int'(dvp_d_o), 0);
    chk("mid_rst_pwdn", int'(dvp_pwdn_o), 1);
    chk("mid_rst_ready", int'(pxl_ready_o), 0);
    chk("mid_rst_uf", int'(underflow_o), 0);
    chk("mid_rst_fd", int'(frame_done_o), 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    rise_cnt = 0;
    repeat (30) @(negedge clk);
    chk("post_rst_no_pclk", rise_cnt, 0);
    chk("post_rst_pwdn", int'(dvp_pwdn_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
